// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous flush and a compile-time first-word-fall-through mode.
module fifo_sync_param #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  input  logic                          i_wr_en,
  input  logic                          i_rd_en,
  input  logic [FIFO_WIDTH-1:0]         i_data_in,
  output logic [FIFO_WIDTH-1:0]         o_data_out,
  output logic                          o_data_valid,
  output logic                          o_wr_ack,
  output logic                          o_overflow,
  output logic                          o_underflow,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almostfull,
  output logic                          o_almostempty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("fifo_sync_param: FIFO_DEPTH must be a power of 2 and >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1) begin : g_err_af
    $error("fifo_sync_param: AF_THRESH out of range 1..FIFO_DEPTH-1");
  end
  if (AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_err_ae
    $error("fifo_sync_param: AE_THRESH out of range 1..FIFO_DEPTH-1");
  end
  if (FIFO_WIDTH < 1) begin : g_err_width
    $error("fifo_sync_param: FIFO_WIDTH must be >= 1");
  end

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // Flush overrides both requests, so neither is accepted nor flagged as rejected
  assign w_wr_acc = i_wr_en & ~w_full & ~i_flush;
  assign w_rd_acc = i_rd_en & ~w_empty & ~i_flush;

  // Storage array: written on accepted writes only, never reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Single-cycle handshake/error pulses reporting the previous cycle's requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= i_wr_en & w_full & ~i_flush;
      r_underflow <= i_rd_en & w_empty & ~i_flush;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented combinationally; zero while empty so reset shows 0
    assign o_data_out   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_data_valid = ~w_empty;
  end else begin : g_reg_read
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    // Registered read: capture head word on an accepted read, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_out   <= '0;
        r_data_valid <= 1'b0;
      end else begin
        r_data_valid <= w_rd_acc;
        if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
      end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
  end

  assign o_wr_ack      = r_wr_ack;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almostfull  = (r_count >= CNT_W'(AF_THRESH)) & ~w_full;
  assign o_almostempty = (r_count <= CNT_W'(AE_THRESH)) & ~w_empty;
  assign o_count       = r_count;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a default registered-read FIFO (16x8) and an FWFT FIFO (8x16),
// table-driven directed vectors, hand sequences and random traffic against queue models.
module tb_fifo_sync_param;

  localparam int W0 = 16;
  localparam int D0 = 8;
  localparam int W1 = 8;
  localparam int D1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;

  logic          f0, w0, r0;
  logic [W0-1:0] din0, dout0;
  logic          dv0, ack0, ovf0, udf0, full0, empty0, af0, ae0;
  logic [3:0]    cnt0;

  logic          f1, w1, r1;
  logic [W1-1:0] din1, dout1;
  logic          dv1, ack1, ovf1, udf1, full1, empty1, af1, ae1;
  logic [4:0]    cnt1;

  fifo_sync_param #(
    .FIFO_WIDTH(W0), .FIFO_DEPTH(D0), .AF_THRESH(D0 - 1), .AE_THRESH(1), .FWFT(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .i_flush(f0), .i_wr_en(w0), .i_rd_en(r0), .i_data_in(din0),
    .o_data_out(dout0), .o_data_valid(dv0), .o_wr_ack(ack0), .o_overflow(ovf0),
    .o_underflow(udf0), .o_full(full0), .o_empty(empty0), .o_almostfull(af0),
    .o_almostempty(ae0), .o_count(cnt0)
  );

  fifo_sync_param #(
    .FIFO_WIDTH(W1), .FIFO_DEPTH(D1), .AF_THRESH(D1 - 1), .AE_THRESH(1), .FWFT(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .i_flush(f1), .i_wr_en(w1), .i_rd_en(r1), .i_data_in(din1),
    .o_data_out(dout1), .o_data_valid(dv1), .o_wr_ack(ack1), .o_overflow(ovf1),
    .o_underflow(udf1), .o_full(full1), .o_empty(empty1), .o_almostfull(af1),
    .o_almostempty(ae1), .o_count(cnt1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference models (queues of stored words) ----------------
  logic [W0-1:0] q0[$];
  logic          m0_ack, m0_ovf, m0_udf, m0_dv;
  logic [W0-1:0] m0_dout;

  logic [W1-1:0] q1[$];
  logic          m1_ack, m1_ovf, m1_udf;

  task automatic drive0(input logic f, input logic w, input logic r, input logic [W0-1:0] d);
    bit full_b, empty_b;
    full_b  = (q0.size() == D0);
    empty_b = (q0.size() == 0);
    f0 = f; w0 = w; r0 = r; din0 = d;
    @(posedge clk);
    #1;
    if (f) begin
      q0.delete();
      m0_ack = 1'b0; m0_ovf = 1'b0; m0_udf = 1'b0; m0_dv = 1'b0;
    end else begin
      m0_ack = w && !full_b;
      m0_ovf = w && full_b;
      m0_udf = r && empty_b;
      m0_dv  = r && !empty_b;
      if (r && !empty_b) m0_dout = q0.pop_front();
      if (w && !full_b) q0.push_back(d);
    end
    f0 = 1'b0; w0 = 1'b0; r0 = 1'b0;
  endtask

  task automatic check_model0(input string tag);
    int n;
    n = q0.size();
    chk({tag, " count"}, 32'(cnt0), 32'(n));
    chk({tag, " full"}, 32'(full0), 32'(n == D0));
    chk({tag, " empty"}, 32'(empty0), 32'(n == 0));
    chk({tag, " almostfull"}, 32'(af0), 32'(n >= D0 - 1 && n < D0));
    chk({tag, " almostempty"}, 32'(ae0), 32'(n <= 1 && n > 0));
    chk({tag, " wr_ack"}, 32'(ack0), 32'(m0_ack));
    chk({tag, " overflow"}, 32'(ovf0), 32'(m0_ovf));
    chk({tag, " underflow"}, 32'(udf0), 32'(m0_udf));
    chk({tag, " data_valid"}, 32'(dv0), 32'(m0_dv));
    chk({tag, " data_out"}, 32'(dout0), 32'(m0_dout));
  endtask

  task automatic drive1(input logic f, input logic w, input logic r, input logic [W1-1:0] d);
    bit full_b, empty_b;
    full_b  = (q1.size() == D1);
    empty_b = (q1.size() == 0);
    f1 = f; w1 = w; r1 = r; din1 = d;
    @(posedge clk);
    #1;
    if (f) begin
      q1.delete();
      m1_ack = 1'b0; m1_ovf = 1'b0; m1_udf = 1'b0;
    end else begin
      m1_ack = w && !full_b;
      m1_ovf = w && full_b;
      m1_udf = r && empty_b;
      if (r && !empty_b) void'(q1.pop_front());
      if (w && !full_b) q1.push_back(d);
    end
    f1 = 1'b0; w1 = 1'b0; r1 = 1'b0;
  endtask

  task automatic check_model1(input string tag);
    int n;
    logic [W1-1:0] head;
    n = q1.size();
    head = (n > 0) ? q1[0] : '0;
    chk({tag, " count"}, 32'(cnt1), 32'(n));
    chk({tag, " full"}, 32'(full1), 32'(n == D1));
    chk({tag, " empty"}, 32'(empty1), 32'(n == 0));
    chk({tag, " almostfull"}, 32'(af1), 32'(n >= D1 - 1 && n < D1));
    chk({tag, " almostempty"}, 32'(ae1), 32'(n <= 1 && n > 0));
    chk({tag, " wr_ack"}, 32'(ack1), 32'(m1_ack));
    chk({tag, " overflow"}, 32'(ovf1), 32'(m1_ovf));
    chk({tag, " underflow"}, 32'(udf1), 32'(m1_udf));
    chk({tag, " data_valid"}, 32'(dv1), 32'(n > 0));
    chk({tag, " data_out"}, 32'(dout1), 32'(head));
  endtask

  task automatic check_reset1(input string tag);
    chk({tag, " count"}, 32'(cnt1), 32'd0);
    chk({tag, " empty"}, 32'(empty1), 32'd1);
    chk({tag, " full"}, 32'(full1), 32'd0);
    chk({tag, " almostfull"}, 32'(af1), 32'd0);
    chk({tag, " almostempty"}, 32'(ae1), 32'd0);
    chk({tag, " data_valid"}, 32'(dv1), 32'd0);
    chk({tag, " data_out"}, 32'(dout1), 32'd0);
    chk({tag, " wr_ack"}, 32'(ack1), 32'd0);
    chk({tag, " overflow"}, 32'(ovf1), 32'd0);
    chk({tag, " underflow"}, 32'(udf1), 32'd0);
  endtask

  // ---------------- directed vector table for the registered-read FIFO ----------------
  typedef struct {
    logic f, w, r;
    logic [W0-1:0] din;
    int cnt;
    logic full, empty, af, ae, ack, ovf, udf, dv;
    logic [W0-1:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic f, input logic w, input logic r,
                               input logic [W0-1:0] din, input int cnt,
                               input logic full, input logic empty, input logic af,
                               input logic ae, input logic ack, input logic ovf,
                               input logic udf, input logic dv, input logic [W0-1:0] dout);
    vec_t v;
    v.f = f; v.w = w; v.r = r; v.din = din; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.ack = ack; v.ovf = ovf; v.udf = udf; v.dv = dv; v.dout = dout;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    f0 = 0; w0 = 0; r0 = 0; din0 = '0;
    f1 = 0; w1 = 0; r1 = 0; din1 = '0;
    m0_ack = 0; m0_ovf = 0; m0_udf = 0; m0_dv = 0; m0_dout = '0;
    m1_ack = 0; m1_ovf = 0; m1_udf = 0;

    // Fill 1..8, overflow, then read-while-full, drain, underflow, mixed ops at empty/count 4
    for (int i = 1; i <= 8; i++)
      addv(0, 1, 0, W0'(i), i, i == 8, 0, i == 7, i == 1, 1, 0, 0, 0, 16'h0);
    addv(0, 1, 0, 16'h0009, 8, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0);
    addv(0, 0, 0, 16'h0000, 8, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    addv(0, 1, 1, 16'h0077, 7, 0, 0, 1, 0, 0, 1, 0, 1, 16'h1);
    for (int k = 1; k <= 7; k++)
      addv(0, 0, 1, 16'h0, 7 - k, 0, k == 7, 0, k == 6, 0, 0, 0, 1, W0'(k + 1));
    addv(0, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h8);
    addv(0, 1, 1, 16'h0055, 1, 0, 0, 0, 1, 1, 0, 1, 0, 16'h8);
    addv(0, 1, 0, 16'h0066, 2, 0, 0, 0, 0, 1, 0, 0, 0, 16'h8);
    addv(0, 1, 0, 16'h0067, 3, 0, 0, 0, 0, 1, 0, 0, 0, 16'h8);
    addv(0, 1, 0, 16'h0068, 4, 0, 0, 0, 0, 1, 0, 0, 0, 16'h8);
    addv(0, 1, 1, 16'h0069, 4, 0, 0, 0, 0, 1, 0, 0, 1, 16'h55);
    addv(0, 0, 0, 16'h0000, 4, 0, 0, 0, 0, 0, 0, 0, 0, 16'h55);

    #12;
    // Reset values while reset is held
    chk("rst count", 32'(cnt0), 32'd0);
    chk("rst empty", 32'(empty0), 32'd1);
    chk("rst full", 32'(full0), 32'd0);
    chk("rst almostfull", 32'(af0), 32'd0);
    chk("rst almostempty", 32'(ae0), 32'd0);
    chk("rst data_valid", 32'(dv0), 32'd0);
    chk("rst data_out", 32'(dout0), 32'd0);
    chk("rst wr_ack", 32'(ack0), 32'd0);
    chk("rst overflow", 32'(ovf0), 32'd0);
    chk("rst underflow", 32'(udf0), 32'd0);
    check_reset1("rst1");
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive0(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].din);
      chk({t, " count"}, 32'(cnt0), 32'(vecs[i].cnt));
      chk({t, " full"}, 32'(full0), 32'(vecs[i].full));
      chk({t, " empty"}, 32'(empty0), 32'(vecs[i].empty));
      chk({t, " almostfull"}, 32'(af0), 32'(vecs[i].af));
      chk({t, " almostempty"}, 32'(ae0), 32'(vecs[i].ae));
      chk({t, " wr_ack"}, 32'(ack0), 32'(vecs[i].ack));
      chk({t, " overflow"}, 32'(ovf0), 32'(vecs[i].ovf));
      chk({t, " underflow"}, 32'(udf0), 32'(vecs[i].udf));
      chk({t, " data_valid"}, 32'(dv0), 32'(vecs[i].dv));
      chk({t, " data_out"}, 32'(dout0), 32'(vecs[i].dout));
    end

    // Flush at count 5 with a concurrent write, then write/read 0xBEEF
    drive0(0, 1, 0, 16'h006A);
    chk("pre-flush count", 32'(cnt0), 32'd5);
    drive0(1, 1, 0, 16'h1234);
    chk("flush count", 32'(cnt0), 32'd0);
    chk("flush empty", 32'(empty0), 32'd1);
    chk("flush wr_ack", 32'(ack0), 32'd0);
    chk("flush data_valid", 32'(dv0), 32'd0);
    chk("flush data_out hold", 32'(dout0), 32'h55);
    drive0(0, 1, 0, 16'hBEEF);
    drive0(0, 0, 1, 16'h0);
    chk("beef data_out", 32'(dout0), 32'hBEEF);
    chk("beef data_valid", 32'(dv0), 32'd1);
    check_model0("post-flush");

    // Pointer wrap: single-entry write/read pairs across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      drive0(0, 1, 0, W0'(16'h0100 + i));
      check_model0("wrap wr");
      drive0(0, 0, 1, 16'h0);
      chk($sformatf("wrap%0d data_out", i), 32'(dout0), 32'(16'h0100 + i));
      check_model0("wrap rd");
    end

    // Random traffic on the registered-read FIFO, alternating fill-heavy and drain-heavy
    for (int i = 0; i < 400; i++) begin
      logic rf, rw, rr;
      int wp;
      wp = (((i / 50) % 2) == 0) ? 7 : 3;
      rf = ($urandom_range(0, 31) == 0);
      rw = ($urandom_range(0, 9) < wp);
      rr = ($urandom_range(0, 9) < (10 - wp));
      drive0(rf, rw, rr, W0'($urandom));
      check_model0("rnd0");
    end

    // FWFT: word visible the cycle after the write with no read
    drive1(0, 1, 0, 8'hA5);
    chk("fwft data_out", 32'(dout1), 32'hA5);
    chk("fwft data_valid", 32'(dv1), 32'd1);
    drive1(0, 0, 1, 8'h00);
    chk("fwft pop empty", 32'(empty1), 32'd1);
    chk("fwft pop data_valid", 32'(dv1), 32'd0);
    check_model1("fwft pop");
    drive1(0, 1, 0, 8'h11);
    drive1(0, 1, 0, 8'h22);
    check_model1("fwft burst");

    // Asynchronous reset mid-burst, between clock edges
    w1 = 1'b1; din1 = 8'h33;
    @(posedge clk);
    #3;
    rst_n1 = 1'b0;
    #1;
    check_reset1("async rst");
    q1.delete();
    m1_ack = 0; m1_ovf = 0; m1_udf = 0;
    w1 = 1'b0;
    #2;
    rst_n1 = 1'b1;
    drive1(0, 1, 0, 8'h3C);
    chk("post-rst data_out", 32'(dout1), 32'h3C);
    check_model1("post-rst");

    // Random traffic on the FWFT FIFO
    for (int i = 0; i < 400; i++) begin
      logic rf, rw, rr;
      int wp;
      wp = (((i / 60) % 2) == 0) ? 7 : 3;
      rf = ($urandom_range(0, 47) == 0);
      rw = ($urandom_range(0, 9) < wp);
      rr = ($urandom_range(0, 9) < (10 - wp));
      drive1(rf, rw, rr, W1'($urandom));
      check_model1("rnd1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO; next generation of the team's fixed 16x8 FIFO. Adds generic width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a compile-time first-word-fall-through (FWFT) mode. Sits between single-clock producer/consumer blocks. Driven by the existing constrained-random FIFO bench through the shared fifo interface.

Parameters:
FIFO_WIDTH, 16, data width in bits (>=1)
FIFO_DEPTH, 8, number of entries; power of 2, >=4
AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH and not full; legal range 1..FIFO_DEPTH-1
AE_THRESH, 1, almostempty asserts when count <= AE_THRESH and not empty; legal range 1..FIFO_DEPTH-1
FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents, highest priority
wr_en  in  1  write request
rd_en  in  1  read request
data_in  in  FIFO_WIDTH  write data
data_out  out  FIFO_WIDTH  read data
data_valid  out  1  data_out qualifier (mode-dependent, see below)
wr_ack  out  1  registered: previous-cycle write accepted
overflow  out  1  registered: previous-cycle write rejected (full)
underflow  out  1  registered: previous-cycle read rejected (empty)
full, empty, almostfull, almostempty  out  1 each  combinational status from count
count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr, rd_ptr, count=0; data_out=0; data_valid, wr_ack, overflow, underflow=0. Therefore empty=1, almostempty=0, full=0, almostfull=0. Memory array is not reset.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- Write accepted when wr_en=1 and full=0. Data is stored at wr_ptr and wr_ptr increments. wr_ack=1 on the next cycle.
- Write rejected when wr_en=1 and full=1. Memory and pointers are unchanged. overflow=1 on the next cycle. This holds even if rd_en=1 in the same cycle; the read still proceeds.
- Read accepted when rd_en=1 and empty=0. rd_ptr increments.
- Read rejected when rd_en=1 and empty=1. underflow=1 on the next cycle. This holds even if wr_en=1 in the same cycle; the write still proceeds.
- count: +1 on an accepted write only; -1 on an accepted read only; unchanged when both are accepted or neither is.
- wr_ack, overflow and underflow are single-cycle pulses, each cleared in any cycle without its triggering event.
- FWFT=0 (registered-read mode):
  - data_out <= mem[rd_ptr] on an accepted read, with 1-cycle latency.
  - data_valid=1 for exactly the cycle after an accepted read.
  - data_out holds its value otherwise.
- FWFT=1 (first-word-fall-through mode):
  - data_out = mem[rd_ptr] combinationally; data_valid = !empty.
  - rd_en acts as a pop/acknowledge of the currently presented word.
  - underflow follows the same empty rule as registered-read mode.
- Flags: full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count>=AF_THRESH) && !full; almostempty = (count<=AE_THRESH) && !empty.
- Flush (flush=1 at a clock edge):
  - Pointers and count go to 0.
  - wr_en/rd_en in that cycle are ignored: no store, and no wr_ack/overflow/underflow next cycle.
  - data_valid=0 next cycle. In registered-read mode, data_out holds its last value.
- Reset asserted mid-operation takes effect immediately regardless of clk and discards all contents. The first post-reset write lands at index 0.
- Elaboration-time check: FIFO_DEPTH must be a power of 2 and thresholds within range; otherwise $error.

Test Plan:
1. Defaults (16x8, FWFT=0). Reset, then write 0x0001..0x0008 on 8 consecutive cycles -> wr_ack=1 each following cycle. count 1..8; almostfull=1 at count 7; full=1 at count 8. A 9th write -> overflow=1 for one cycle, count stays 8.
2. From full, read 8 times -> data_out 0x0001..0x0008, each one cycle after rd_en, with data_valid pulse. almostempty=1 at count 1; empty=1 at 0. A 9th read -> underflow=1, data_out holds 0x0008.
3. Simultaneous rd_en and wr_en:
   - At count=4 -> count stays 4, wr_ack=1, data_valid=1.
   - At full -> read only, overflow=1, count 7.
   - At empty -> write only, underflow=1, count 1.
4. Wrap-around: 20 iterations of write-then-read of incrementing data through depth 8 -> output sequence matches input with no loss or duplication across pointer wrap.
5. Flush at count=5 with wr_en=1 -> next cycle count=0, empty=1, no wr_ack. A subsequent write of 0xBEEF is read back as 0xBEEF.
6. FWFT=1, FIFO_WIDTH=8, FIFO_DEPTH=16:
   - Write 0xA5 -> data_out=0xA5 and data_valid=1 the cycle after the write, with no rd_en.
   - rd_en -> empty=1, data_valid=0.
   - Assert rst_n=0 mid-burst -> all outputs at reset values before the next clk edge.
